// File: rtl/resonator_pkg.sv
// Shared types and helpers for the multi-channel resonator.
// RESONATOR_SAT_EN selects saturating (defined) or wrapping (undefined) narrowing in shrink().
package resonator_pkg;

  typedef enum logic [1:0] {IDLE, MAC_B, MAC_A0, MAC_A1} state_t;

  typedef enum logic [1:0] {OP_HOLD, OP_LOAD, OP_ADD, OP_SUB} mac_op_t;

  function automatic int unsigned acc_w(input int unsigned data_w);
    return 2 * data_w + 3;
  endfunction

  // Floor-shift by frac_w, then narrow to data_w bits (result sign-extended to 64 bits).
  function automatic logic signed [63:0] shrink(input logic signed [63:0] acc,
                                                input int unsigned frac_w,
                                                input int unsigned data_w);
    logic signed [63:0] s;
`ifdef RESONATOR_SAT_EN
    logic signed [63:0] lim_hi;
    logic signed [63:0] lim_lo;
`endif
    s = acc >>> frac_w;
`ifdef RESONATOR_SAT_EN
    lim_hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lim_lo = -(64'sd1 <<< (data_w - 1));
    if (s > lim_hi) begin
      s = lim_hi;
    end else if (s < lim_lo) begin
      s = lim_lo;
    end
`else
    s = (s <<< (64 - data_w)) >>> (64 - data_w);
`endif
    return s;
  endfunction

endpackage

// File: rtl/resonator_mc_if.sv
// Sample/coefficient/result bundle of the resonator; master drives samples, slave is the block.
interface resonator_mc_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CH_W   = 2
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic [CH_W-1:0]          in_ch;
  logic signed [DATA_W-1:0] coef_b;
  logic signed [DATA_W-1:0] coef_a0;
  logic signed [DATA_W-1:0] coef_a1;
  logic                     hist_clr;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic [CH_W-1:0]          out_ch;
  logic                     ch_err;

  modport master (
    output in_valid, in_data, in_ch, coef_b, coef_a0, coef_a1, hist_clr,
    input  in_ready, out_valid, out_data, out_ch, ch_err
  );

  modport slave (
    input  in_valid, in_data, in_ch, coef_b, coef_a0, coef_a1, hist_clr,
    output in_ready, out_valid, out_data, out_ch, ch_err
  );
endinterface

// File: rtl/resonator_mac.sv
// Shared signed multiplier with accumulator; final_acc = acc - product, used in the last MAC step.
module resonator_mac
  import resonator_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  mac_op_t                             op,
  input  logic signed [DATA_W-1:0]            coef,
  input  logic signed [DATA_W:0]              operand,
  output logic signed [acc_w(DATA_W)-1:0]     final_acc
);
  localparam int unsigned ACC_W  = acc_w(DATA_W);
  localparam int unsigned PROD_W = 2 * DATA_W + 1;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_q;

  assign prod      = PROD_W'(coef) * PROD_W'(operand);
  assign prod_ext  = ACC_W'(prod);
  assign final_acc = acc_q - prod_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      unique case (op)
        OP_LOAD: acc_q <= prod_ext;
        OP_ADD:  acc_q <= acc_q + prod_ext;
        OP_SUB:  acc_q <= final_acc;
        default: acc_q <= acc_q;
      endcase
    end
  end
endmodule

// File: rtl/resonator_mc.sv
// Time-multiplexed multi-channel resonator: y = b*(x-x2) + a0*y1 - a1*y2, one product per clock.
// Narrowing of the result is set by RESONATOR_SAT_EN (see resonator_pkg::shrink).
module resonator_mc
  import resonator_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned NCH    = 4
) (
  input logic           clk,
  input logic           reset,
  resonator_mc_if.slave bus
);
  localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned ACC_W = acc_w(DATA_W);

  state_t                   state_q;
  logic signed [DATA_W-1:0] x_q, cb_q, ca0_q, ca1_q;
  logic [CH_W-1:0]          ch_q;
  logic signed [DATA_W-1:0] x1_q [NCH];
  logic signed [DATA_W-1:0] x2_q [NCH];
  logic signed [DATA_W-1:0] y1_q [NCH];
  logic signed [DATA_W-1:0] y2_q [NCH];
  logic                     out_valid_q, ch_err_q;
  logic signed [DATA_W-1:0] out_data_q;
  logic [CH_W-1:0]          out_ch_q;

  mac_op_t                  mac_op;
  logic signed [DATA_W-1:0] mac_coef;
  logic signed [DATA_W:0]   mac_operand;
  logic signed [DATA_W:0]   diff;
  logic signed [ACC_W-1:0]  mac_final;
  logic signed [DATA_W-1:0] y_new;
  logic                     ch_bad;

  // Out-of-range channels are only possible when NCH is not a power of two.
  if (NCH == (1 << CH_W)) begin : g_pow2
    assign ch_bad = 1'b0;
  end else begin : g_npow2
    assign ch_bad = (bus.in_ch >= CH_W'(NCH));
  end

  assign bus.in_ready  = (state_q == IDLE) && !bus.hist_clr;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.ch_err    = ch_err_q;

  assign diff  = (DATA_W + 1)'(x_q) - (DATA_W + 1)'(x2_q[ch_q]);
  assign y_new = DATA_W'(shrink(64'(mac_final), FRAC_W, DATA_W));

  always_comb begin
    mac_op      = OP_HOLD;
    mac_coef    = cb_q;
    mac_operand = diff;
    unique case (state_q)
      MAC_B:  mac_op = OP_LOAD;
      MAC_A0: begin
        mac_op      = OP_ADD;
        mac_coef    = ca0_q;
        mac_operand = (DATA_W + 1)'(y1_q[ch_q]);
      end
      MAC_A1: begin
        mac_op      = OP_SUB;
        mac_coef    = ca1_q;
        mac_operand = (DATA_W + 1)'(y2_q[ch_q]);
      end
      default: ;
    endcase
  end

  resonator_mac #(
    .DATA_W (DATA_W)
  ) u_mac (
    .clk       (clk),
    .reset     (reset),
    .op        (mac_op),
    .coef      (mac_coef),
    .operand   (mac_operand),
    .final_acc (mac_final)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      cb_q        <= '0;
      ca0_q       <= '0;
      ca1_q       <= '0;
      ch_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ch_err_q    <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
        x1_q[i] <= '0;
        x2_q[i] <= '0;
        y1_q[i] <= '0;
        y2_q[i] <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      ch_err_q    <= 1'b0;
      if (bus.hist_clr) begin
        // Clear wins over completion and over any transfer this cycle.
        state_q <= IDLE;
        for (int unsigned i = 0; i < NCH; i++) begin
          x1_q[i] <= '0;
          x2_q[i] <= '0;
          y1_q[i] <= '0;
          y2_q[i] <= '0;
        end
      end else begin
        unique case (state_q)
          IDLE: begin
            if (bus.in_valid) begin
              x_q   <= bus.in_data;
              ch_q  <= bus.in_ch;
              cb_q  <= bus.coef_b;
              ca0_q <= bus.coef_a0;
              ca1_q <= bus.coef_a1;
              if (ch_bad) begin
                ch_err_q <= 1'b1;
              end else begin
                state_q <= MAC_B;
              end
            end
          end
          MAC_B:  state_q <= MAC_A0;
          MAC_A0: state_q <= MAC_A1;
          MAC_A1: begin
            state_q     <= IDLE;
            out_valid_q <= 1'b1;
            out_data_q  <= y_new;
            out_ch_q    <= ch_q;
            x2_q[ch_q]  <= x1_q[ch_q];
            x1_q[ch_q]  <= x_q;
            y2_q[ch_q]  <= y1_q[ch_q];
            y1_q[ch_q]  <= y_new;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_resonator_mc.sv
// Bench for resonator_mc: arithmetic reference model + per-cycle compare, plus literal spot checks.
module tb_resonator_mc;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  resonator_mc_if #(.DATA_W(16), .CH_W(2)) bus0 ();
  resonator_mc_if #(.DATA_W(16), .CH_W(2)) bus1 ();

  resonator_mc #(.DATA_W(16), .FRAC_W(8), .NCH(4)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  resonator_mc #(.DATA_W(16), .FRAC_W(8), .NCH(3)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %04h expected %04h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on per-channel histories.
  typedef struct {int ch; logic [15:0] data; int due;} exp_t;
  exp_t exp_q[$];
  longint mx1[4], mx2[4], my1[4], my2[4];
  logic signed [15:0] cb, ca0, ca1;

  function automatic logic [15:0] model_step(input int ch, input logic signed [15:0] xv,
                                             input logic signed [15:0] bv,
                                             input logic signed [15:0] a0v,
                                             input logic signed [15:0] a1v);
    longint x, b, a0, a1, acc, s, y;
    x = xv; b = bv; a0 = a0v; a1 = a1v;
    acc = b * (x - mx2[ch]) + a0 * my1[ch] - a1 * my2[ch];
    s = acc >>> 8;
`ifdef RESONATOR_SAT_EN
    y = (s > 32767) ? 32767 : (s < -32768) ? -32768 : s;
`else
    y = ((s + 32768) & 65535) - 32768;
`endif
    mx2[ch] = mx1[ch]; mx1[ch] = x; my2[ch] = my1[ch]; my1[ch] = y;
    return 16'(y);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      mx1[i] = 0; mx2[i] = 0; my1[i] = 0; my2[i] = 0;
    end
    exp_q.delete();
  endtask

  logic [15:0] log_d[$];
  logic [15:0] log_c[$];

  // Compare process for dut0: every cycle, out_valid must match the model's schedule.
  always @(negedge clk) begin
    if (!reset) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        check("out_valid0 due", 16'(bus0.out_valid), 16'd1);
        check("out_data0", bus0.out_data, exp_q[0].data);
        check("out_ch0", 16'(bus0.out_ch), 16'(exp_q[0].ch));
        log_d.push_back(bus0.out_data);
        log_c.push_back(16'(bus0.out_ch));
        void'(exp_q.pop_front());
      end else begin
        check("out_valid0 idle", 16'(bus0.out_valid), 16'd0);
      end
      check("ch_err0", 16'(bus0.ch_err), 16'd0);
    end
  end

  int ov1_cnt = 0;
  logic [15:0] last1_d, last1_c;
  always @(negedge clk) begin
    if (!reset && bus1.out_valid) begin
      ov1_cnt <= ov1_cnt + 1;
      last1_d <= bus1.out_data;
      last1_c <= 16'(bus1.out_ch);
    end
  end

  task automatic send(input int ch, input logic signed [15:0] x);
    int c = 0;
    int waited = 0;
    bit ok = 0;
    @(negedge clk);
    bus0.in_valid = 1'b1; bus0.in_data = x; bus0.in_ch = 2'(ch);
    bus0.coef_b = cb; bus0.coef_a0 = ca0; bus0.coef_a1 = ca1;
    while (!ok && waited < 20) begin
      #1;
      c = cyc;
      if (bus0.in_ready) begin
        @(posedge clk);
        ok = 1;
      end else begin
        @(negedge clk);
        waited++;
      end
    end
    if (ok) begin
      exp_q.push_back('{ch: ch, data: model_step(ch, x, cb, ca0, ca1), due: c + 4});
      last_acc = c;
      #1;
      // Coefficients moving after the transfer must not affect this sample.
      bus0.coef_b = 16'h5A5A; bus0.coef_a0 = 16'hA5A5; bus0.coef_a1 = 16'h7777;
    end else begin
      check("send timeout", 16'd0, 16'd1);
    end
    bus0.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) check("drain timeout", 16'(exp_q.size()), 16'd0);
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus0.hist_clr = 1'b1;
    model_clear();
    @(negedge clk);
    bus0.hist_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int acc_cyc[4];
    cb = 16'sh0100; ca0 = 16'sh01D3; ca1 = 16'sh00FB;
    reset = 1'b1;
    bus0.in_valid = 0; bus0.in_data = 0; bus0.in_ch = 0; bus0.hist_clr = 0;
    bus0.coef_b = cb; bus0.coef_a0 = ca0; bus0.coef_a1 = ca1;
    bus1.in_valid = 0; bus1.in_data = 0; bus1.in_ch = 0; bus1.hist_clr = 0;
    bus1.coef_b = cb; bus1.coef_a0 = ca0; bus1.coef_a1 = ca1;
    model_clear();
    #1;
    check("rst out_valid", 16'(bus0.out_valid), 16'd0);
    check("rst out_data", bus0.out_data, 16'h0000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst in_ready", 16'(bus0.in_ready), 16'd1);
    check("rst out_ch", 16'(bus0.out_ch), 16'd0);
    check("rst ch_err", 16'(bus0.ch_err), 16'd0);

    // Impulse on ch0
    base = log_d.size();
    send(0, 16'sh0100); send(0, 16'sh0000); send(0, 16'sh0000);
    drain();
    check("impulse count", 16'(log_d.size() - base), 16'd3);
    check("impulse y0", log_d[base], 16'h0100);
    check("impulse y1", log_d[base+1], 16'h01D3);
    check("impulse y2", log_d[base+2], 16'h0158);

    // Isolation: ch0 impulse interleaved with ch1 zeros
    pulse_clr();
    base = log_d.size();
    send(0, 16'sh0100); send(1, 16'sh0000); send(0, 16'sh0000);
    send(1, 16'sh0000); send(0, 16'sh0000); send(1, 16'sh0000);
    drain();
    check("iso ch0 y0", log_d[base], 16'h0100);
    check("iso ch1 y0", log_d[base+1], 16'h0000);
    check("iso ch1 tag", log_c[base+1], 16'd1);
    check("iso ch0 y1", log_d[base+2], 16'h01D3);
    check("iso ch0 y2", log_d[base+4], 16'h0158);
    check("iso ch1 y2", log_d[base+5], 16'h0000);

    // Reset during MAC_A0
    pulse_clr();
    send(0, 16'sh0100);
    drain();
    send(0, 16'sh0000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    #1;
    check("midrst out_valid", 16'(bus0.out_valid), 16'd0);
    check("midrst out_data", bus0.out_data, 16'h0000);
    check("midrst ch_err", 16'(bus0.ch_err), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst in_ready", 16'(bus0.in_ready), 16'd1);
    base = log_d.size();
    send(0, 16'sh0100);
    drain();
    check("post-rst y0", log_d[base], 16'h0100);

    // Overflow narrowing
    pulse_clr();
    cb = 16'sh0400; ca0 = 16'sh0000; ca1 = 16'sh0000;
    base = log_d.size();
    send(2, 16'sh7FFF);
    drain();
`ifdef RESONATOR_SAT_EN
    check("overflow sat", log_d[base], 16'h7FFF);
`else
    check("overflow wrap", log_d[base], 16'hFFFC);
`endif
    cb = 16'sh0100; ca0 = 16'sh01D3; ca1 = 16'sh00FB;

    // Handshake: back-to-back requests accepted every 4 clocks
    pulse_clr();
    for (int i = 0; i < 4; i++) begin
      send(3, 16'(16'sh0040 * (i + 1)));
      acc_cyc[i] = last_acc;
    end
    for (int i = 1; i < 4; i++) check("accept spacing", 16'(acc_cyc[i] - acc_cyc[i-1]), 16'd4);
    drain();

    // hist_clr during MAC_A0 drops the sample and blocks a same-cycle transfer
    pulse_clr();
    send(0, 16'sh0100);
    @(negedge clk);
    @(negedge clk);
    bus0.hist_clr = 1'b1;
    model_clear();
    @(negedge clk);
    bus0.in_valid = 1'b1; bus0.in_data = 16'sh1234; bus0.in_ch = 2'd0;
    #1;
    check("clr in_ready", 16'(bus0.in_ready), 16'd0);
    @(negedge clk);
    bus0.hist_clr = 1'b0; bus0.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    base = log_d.size();
    send(0, 16'sh0100);
    drain();
    check("post-clr count", 16'(log_d.size() - base), 16'd1);
    check("post-clr y0", log_d[base], 16'h0100);

    // NCH=3 instance: channel 3 is out of range
    @(negedge clk);
    bus1.in_valid = 1'b1; bus1.in_ch = 2'd3; bus1.in_data = 16'sh0100;
    #1;
    check("err in_ready", 16'(bus1.in_ready), 16'd1);
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    @(negedge clk);
    check("ch_err pulse", 16'(bus1.ch_err), 16'd1);
    check("err no out_valid", 16'(bus1.out_valid), 16'd0);
    @(negedge clk);
    check("ch_err one cycle", 16'(bus1.ch_err), 16'd0);
    repeat (5) @(negedge clk);
    check("err outputs", 16'(ov1_cnt), 16'd0);
    bus1.in_valid = 1'b1; bus1.in_ch = 2'd2; bus1.in_data = 16'sh0100;
    #1;
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("nch3 count", 16'(ov1_cnt), 16'd1);
    check("nch3 y0", last1_d, 16'h0100);
    check("nch3 ch", last1_c, 16'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
